// File: rtl/router_pkg.sv
// Shared router types and constants: packet field positions, requester indices, arbiter state.
package router_pkg;

  localparam int unsigned PKT_W  = 16;
  localparam int unsigned DX_MSB = 15;
  localparam int unsigned DX_LSB = 12;
  localparam int unsigned DY_MSB = 11;
  localparam int unsigned DY_LSB = 8;

  localparam int unsigned REQ_NORTH = 0;
  localparam int unsigned REQ_EAST  = 1;
  localparam int unsigned REQ_WEST  = 2;
  localparam int unsigned REQ_LOCAL = 3;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit at or after ptr, wrapping at N-1.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] pos;
  logic [IDX_W-1:0] idx;
  logic             found;

  // Wrap is an explicit compare so non-power-of-two N works.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + SUM_W'(k);
      if (pos > SUM_W'(N - 1)) pos = pos - SUM_W'(N);
      idx = pos[IDX_W-1:0];
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    if (en && found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/south_port_arbiter.sv
// South output port: round-robin over NUM_REQ requesters into a one-entry output register.
// Optional per-requester grant counters when SOUTH_ARB_STATS_EN is defined.
module south_port_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PKT_W   = router_pkg::PKT_W,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ*PKT_W-1:0] req_packet,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [PKT_W-1:0]         packet_south,
  output logic                     valid_south,
  input  logic                     ready_south,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     busy
`ifdef SOUTH_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]    grant_count,
  input  logic                     stats_clr
`endif
);

  import router_pkg::*;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PKT_W-1:0] packet_q, packet_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] win_idx;
  logic             can_accept;
  logic             xfer;
  logic [PKT_W-1:0] pkts [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign pkts[i] = req_packet[i*PKT_W +: PKT_W];
  end

  assign can_accept = (state_q == ARB_EMPTY) | ready_south;
  assign xfer       = can_accept & (|req_valid);

  // rst_n gate keeps every requester un-granted while reset is held.
  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (can_accept & rst_n),
    .gnt     (req_ready),
    .gnt_idx (win_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_EMPTY;
      rr_ptr_q <= '0;
      packet_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      packet_q <= packet_d;
      grant_q  <= grant_d;
    end
  end

  // Refill on the same edge as drain gives one packet per cycle.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    packet_d = packet_q;
    grant_d  = grant_q;
    if (xfer) begin
      state_d  = ARB_FULL;
      packet_d = pkts[win_idx];
      grant_d  = win_idx;
      rr_ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
    end else if (state_q == ARB_FULL && ready_south) begin
      state_d = ARB_EMPTY;
    end
  end

  assign packet_south = packet_q;
  assign valid_south  = (state_q == ARB_FULL);
  assign grant_id     = grant_q;
  assign busy         = valid_south;

`ifdef SOUTH_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  // Saturating counters; a simultaneous clear beats the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (stats_clr) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (xfer && cnt_q[win_idx] != 16'hFFFF) begin
      cnt_q[win_idx] <= cnt_q[win_idx] + 16'd1;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    assign grant_count[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_south_port_arbiter.sv
// Randomised self-checking bench for south_port_arbiter against a queue-free behavioural model.
module tb_south_port_arbiter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] req_packet = '0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [15:0] packet_south;
  logic        valid_south;
  logic        ready_south = 1'b0;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef SOUTH_ARB_STATS_EN
  logic [63:0] grant_count;
  logic        stats_clr = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  // Model state
  bit          m_full;
  logic [15:0] m_pkt;
  int          m_gid;
  int          m_ptr;
  int          m_cnt [N];

  south_port_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_packet   (req_packet),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .packet_south (packet_south),
    .valid_south  (valid_south),
    .ready_south  (ready_south),
    .grant_id     (grant_id),
    .busy         (busy)
`ifdef SOUTH_ARB_STATS_EN
    ,
    .grant_count  (grant_count),
    .stats_clr    (stats_clr)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int model_win(logic [3:0] v);
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    logic [3:0] r = '0;
    int w = model_win(req_valid);
    if (rst_n && (!m_full || ready_south) && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_full = 1'b0;
    m_pkt  = '0;
    m_gid  = 0;
    m_ptr  = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic model_edge();
    int w = model_win(req_valid);
    bit can = !m_full || ready_south;
`ifdef SOUTH_ARB_STATS_EN
    if (stats_clr) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (can && w >= 0 && m_cnt[w] < 65535) begin
      m_cnt[w]++;
    end
`endif
    if (can && w >= 0) begin
      m_full = 1'b1;
      m_pkt  = req_packet[w*16 +: 16];
      m_gid  = w;
      m_ptr  = (w + 1) % N;
    end else if (m_full && ready_south) begin
      m_full = 1'b0;
    end
  endtask

  task automatic set_pkt(int i, logic [15:0] p);
    req_packet[i*16 +: 16] = p;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    ready_south = 1'b0;
`ifdef SOUTH_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = 4'hF;
    ready_south = 1'b1;
    model_reset();
    #3;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (valid_south !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid_south); end
    checks++; if (packet_south !== 16'h0000) begin failures++; $display("FAIL reset_packet: got %h expected 0000", packet_south); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    checks++; if (valid_south !== 1'b0) begin failures++; $display("FAIL reset_hold_valid: got %b expected 0", valid_south); end
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    set_pkt(0, 16'h0300);
    req_valid = 4'b0001;
    ready_south = 1'b1;
    #3;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
    model_edge();
    @(posedge clk); #1;
    req_valid = '0;
    checks++; if (valid_south !== 1'b1) begin failures++; $display("FAIL single_valid: got %b expected 1", valid_south); end
    checks++; if (packet_south !== 16'h0300) begin failures++; $display("FAIL single_packet: got %h expected 0300", packet_south); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL single_grant: got %0d expected 0", grant_id); end
  endtask

  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) set_pkt(i, 16'hA000 + 16'(i));
    req_valid = 4'hF;
    ready_south = 1'b1;
    for (int c = 0; c < 5; c++) begin
      logic [3:0]  er = 4'(1 << seq[c]);
      logic [15:0] ep = 16'hA000 + 16'(seq[c]);
      #3;
      checks++; if (req_ready !== er) begin failures++; $display("FAIL rr_ready[%0d]: got %b expected %b", c, req_ready, er); end
      model_edge();
      @(posedge clk); #1;
      checks++; if (grant_id !== 2'(seq[c])) begin failures++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", c, grant_id, seq[c]); end
      checks++; if (packet_south !== ep) begin failures++; $display("FAIL rr_packet[%0d]: got %h expected %h", c, packet_south, ep); end
      checks++; if (valid_south !== 1'b1) begin failures++; $display("FAIL rr_valid[%0d]: got %b expected 1", c, valid_south); end
    end
    req_valid = '0;
  endtask

  task automatic test_stall();
    do_reset();
    set_pkt(0, 16'h0500);
    req_valid = 4'b0001;
    ready_south = 1'b0;
    #3;
    model_edge();
    @(posedge clk); #1;
    set_pkt(1, 16'h1111);
    set_pkt(2, 16'h2222);
    req_valid = 4'b0110;
    for (int c = 0; c < 3; c++) begin
      #3;
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL stall_ready[%0d]: got %b expected 0000", c, req_ready); end
      model_edge();
      @(posedge clk); #1;
      checks++; if (packet_south !== 16'h0500) begin failures++; $display("FAIL stall_packet[%0d]: got %h expected 0500", c, packet_south); end
      checks++; if (valid_south !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d]: got %b expected 1", c, valid_south); end
    end
    ready_south = 1'b1;
    #3;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL stall_release_ready: got %b expected 0010", req_ready); end
    model_edge();
    @(posedge clk); #1;
    checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL stall_release_grant: got %0d expected 1", grant_id); end
    checks++; if (packet_south !== 16'h1111) begin failures++; $display("FAIL stall_release_packet: got %h expected 1111", packet_south); end
    req_valid = '0;
  endtask

  task automatic test_drain();
    do_reset();
    set_pkt(3, 16'h0F0F);
    req_valid = 4'b1000;
    ready_south = 1'b1;
    #3;
    model_edge();
    @(posedge clk); #1;
    req_valid = '0;
    checks++; if (valid_south !== 1'b1) begin failures++; $display("FAIL drain_valid_hi: got %b expected 1", valid_south); end
    #3;
    model_edge();
    @(posedge clk); #1;
    checks++; if (valid_south !== 1'b0) begin failures++; $display("FAIL drain_valid_lo: got %b expected 0", valid_south); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drain_busy: got %b expected 0", busy); end
    checks++; if (packet_south !== 16'h0F0F) begin failures++; $display("FAIL drain_packet_hold: got %h expected 0f0f", packet_south); end
    checks++; if (grant_id !== 2'd3) begin failures++; $display("FAIL drain_grant_hold: got %0d expected 3", grant_id); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_pkt(2, 16'h0222);
    req_valid = 4'b0100;
    ready_south = 1'b0;
    #3;
    model_edge();
    @(posedge clk); #1;
    req_valid = '0;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (valid_south !== 1'b0) begin failures++; $display("FAIL async_valid: got %b expected 0", valid_south); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_busy: got %b expected 0", busy); end
    checks++; if (packet_south !== 16'h0000) begin failures++; $display("FAIL async_packet: got %h expected 0000", packet_south); end
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_pkt(3, 16'h0333);
    req_valid = 4'b1000;
    ready_south = 1'b1;
    #3;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL async_post_ready: got %b expected 1000", req_ready); end
    model_edge();
    @(posedge clk); #1;
    checks++; if (grant_id !== 2'd3) begin failures++; $display("FAIL async_post_grant: got %0d expected 3", grant_id); end
    checks++; if (packet_south !== 16'h0333) begin failures++; $display("FAIL async_post_packet: got %h expected 0333", packet_south); end
    req_valid = 4'hF;
    #3;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL async_wrap_ready: got %b expected 0001", req_ready); end
    model_edge();
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [3:0] granted = '0;
    logic [3:0] exp_r;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || granted[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          set_pkt(i, 16'($urandom));
        end
      end
      ready_south = ($urandom_range(0, 3) != 0);
      #3;
      exp_r = model_ready();
      checks++; if (req_ready !== exp_r) begin failures++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, req_ready, exp_r); end
      granted = req_ready;
      model_edge();
      @(posedge clk); #1;
      checks++; if (valid_south !== m_full) begin failures++; $display("FAIL rand_valid[%0d]: got %b expected %b", c, valid_south, m_full); end
      checks++; if (busy !== m_full) begin failures++; $display("FAIL rand_busy[%0d]: got %b expected %b", c, busy, m_full); end
      checks++; if (packet_south !== m_pkt) begin failures++; $display("FAIL rand_packet[%0d]: got %h expected %h", c, packet_south, m_pkt); end
      checks++; if (grant_id !== 2'(m_gid)) begin failures++; $display("FAIL rand_grant[%0d]: got %0d expected %0d", c, grant_id, m_gid); end
    end
    req_valid = '0;
  endtask

`ifdef SOUTH_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    set_pkt(2, 16'h0C0C);
    req_valid = 4'b0100;
    ready_south = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #3;
      model_edge();
      @(posedge clk); #1;
    end
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      checks++; if (grant_count[i*16 +: 16] !== 16'(m_cnt[i])) begin failures++; $display("FAIL stats_count[%0d]: got %0d expected %0d", i, grant_count[i*16 +: 16], m_cnt[i]); end
    end
    checks++; if (grant_count[47:32] !== 16'd5) begin failures++; $display("FAIL stats_count_req2: got %0d expected 5", grant_count[47:32]); end
    stats_clr = 1'b1;
    req_valid = 4'b0100;
    #3;
    model_edge();
    @(posedge clk); #1;
    stats_clr = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      checks++; if (grant_count[i*16 +: 16] !== 16'd0) begin failures++; $display("FAIL stats_clear[%0d]: got %0d expected 0", i, grant_count[i*16 +: 16]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_drain();
    test_async_reset();
    test_random();
`ifdef SOUTH_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
